// File: rtl/morse_char_encoder.sv
// ASCII-to-Morse feeder: FIFO-buffers chars, issues LSB-first code words to the sequencer, inserts letter/word gaps.
// Latency: char pushed at edge N into an idle, empty block gives send_o in cycle N+3; per letter 4 + done latency + LETTER_GAP_CYC.
// Backpressure: char_ready_o = !full. Build macro MORSE_TIMEOUT_EN adds a done_i watchdog in WAIT_DONE.
module morse_char_encoder #(
   parameter int FIFO_DEPTH     = 8,
   parameter int CODE_W         = 8,
   parameter int LETTER_GAP_CYC = 16,
   parameter int WORD_GAP_CYC   = 64,
   parameter int TIMEOUT_CYC    = 4096
) (
   input  logic                        clk_i,
   input  logic                        rst_i,
   input  logic [7:0]                  char_i,
   input  logic                        char_valid_i,
   output logic                        char_ready_o,
   output logic [CODE_W-1:0]           code_o,
   output logic [5:0]                  len_o,
   output logic                        send_o,
   input  logic                        done_i,
   output logic                        busy_o,
   output logic                        err_o,
   output logic [$clog2(FIFO_DEPTH):0] fifo_level_o
);
   localparam int AW        = $clog2(FIFO_DEPTH);
   localparam int LW        = AW + 1;
   localparam int GAP_MAX_A = (LETTER_GAP_CYC > WORD_GAP_CYC) ? LETTER_GAP_CYC : WORD_GAP_CYC;
   localparam int GAP_MAX   = (GAP_MAX_A > TIMEOUT_CYC) ? GAP_MAX_A : TIMEOUT_CYC;
   localparam int GW        = $clog2(GAP_MAX + 1);
   localparam logic [GW-1:0] LETTER_GAP = GW'(LETTER_GAP_CYC);
   localparam logic [GW-1:0] WORD_GAP   = GW'(WORD_GAP_CYC);
   localparam logic [LW-1:0] FULL_LVL   = LW'(FIFO_DEPTH);

   typedef enum logic [2:0] {IDLE, FETCH, LOOKUP, SEND, WAIT_DONE, GAP} state_t;

   state_t        state_q, state_d;
   logic [7:0]    mem [FIFO_DEPTH];
   logic [AW-1:0] wr_ptr, rd_ptr;
   logic [LW-1:0] level;
   logic          push, pop;
   logic [7:0]    char_q, c_up;
   logic [8:0]    rom;            // {supported, len-1, code}
   logic [GW-1:0] gap_q, gap_d;
   logic          load_code, set_err;

   assign char_ready_o = (level != FULL_LVL);
   assign push         = char_valid_i && char_ready_o;
   assign fifo_level_o = level;
   assign send_o       = (state_q == SEND);
   assign busy_o       = (state_q != IDLE) || (level != '0);

   always_ff @(posedge clk_i) begin
      if (push) mem[wr_ptr] <= char_i;
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         level  <= '0;
      end else begin
         if (push) wr_ptr <= wr_ptr + AW'(1);
         if (pop)  rd_ptr <= rd_ptr + AW'(1);
         case ({push, pop})
            2'b10:   level <= level + LW'(1);
            2'b01:   level <= level - LW'(1);
            default: ;
         endcase
      end
   end

   // Lowercase folds onto uppercase; code bit 0 is the first symbol, 1 = dash.
   always_comb begin
      c_up = char_q;
      if (char_q >= "a" && char_q <= "z") c_up = char_q - 8'h20;
      rom = '0;
      case (c_up)
         "A": rom = {1'b1, 3'd1, 5'h02};
         "B": rom = {1'b1, 3'd3, 5'h01};
         "C": rom = {1'b1, 3'd3, 5'h05};
         "D": rom = {1'b1, 3'd2, 5'h01};
         "E": rom = {1'b1, 3'd0, 5'h00};
         "F": rom = {1'b1, 3'd3, 5'h04};
         "G": rom = {1'b1, 3'd2, 5'h03};
         "H": rom = {1'b1, 3'd3, 5'h00};
         "I": rom = {1'b1, 3'd1, 5'h00};
         "J": rom = {1'b1, 3'd3, 5'h0E};
         "K": rom = {1'b1, 3'd2, 5'h05};
         "L": rom = {1'b1, 3'd3, 5'h02};
         "M": rom = {1'b1, 3'd1, 5'h03};
         "N": rom = {1'b1, 3'd1, 5'h01};
         "O": rom = {1'b1, 3'd2, 5'h07};
         "P": rom = {1'b1, 3'd3, 5'h06};
         "Q": rom = {1'b1, 3'd3, 5'h0B};
         "R": rom = {1'b1, 3'd2, 5'h02};
         "S": rom = {1'b1, 3'd2, 5'h00};
         "T": rom = {1'b1, 3'd0, 5'h01};
         "U": rom = {1'b1, 3'd2, 5'h04};
         "V": rom = {1'b1, 3'd3, 5'h08};
         "W": rom = {1'b1, 3'd2, 5'h06};
         "X": rom = {1'b1, 3'd3, 5'h09};
         "Y": rom = {1'b1, 3'd3, 5'h0D};
         "Z": rom = {1'b1, 3'd3, 5'h03};
         "0": rom = {1'b1, 3'd4, 5'h1F};
         "1": rom = {1'b1, 3'd4, 5'h1E};
         "2": rom = {1'b1, 3'd4, 5'h1C};
         "3": rom = {1'b1, 3'd4, 5'h18};
         "4": rom = {1'b1, 3'd4, 5'h10};
         "5": rom = {1'b1, 3'd4, 5'h00};
         "6": rom = {1'b1, 3'd4, 5'h01};
         "7": rom = {1'b1, 3'd4, 5'h03};
         "8": rom = {1'b1, 3'd4, 5'h07};
         "9": rom = {1'b1, 3'd4, 5'h0F};
         default: rom = '0;
      endcase
   end

`ifdef MORSE_TIMEOUT_EN
   localparam logic [GW-1:0] TO_LIM = GW'(TIMEOUT_CYC - 1);
   logic [GW-1:0] wd_q;

   always_ff @(posedge clk_i) begin
      if (rst_i || state_q != WAIT_DONE) wd_q <= '0;
      else                               wd_q <= wd_q + GW'(1);
   end
`endif

   always_comb begin
      state_d   = state_q;
      gap_d     = gap_q;
      load_code = 1'b0;
      set_err   = 1'b0;
      pop       = 1'b0;
      case (state_q)
         IDLE:   if (level != '0) state_d = FETCH;
         FETCH: begin
            pop     = 1'b1;
            state_d = LOOKUP;
         end
         LOOKUP: begin
            if (rom[8]) begin
               load_code = 1'b1;
               state_d   = SEND;
            end else if (char_q == 8'h20) begin
               gap_d   = WORD_GAP;
               state_d = GAP;
            end else begin
               set_err = 1'b1;
               state_d = IDLE;
            end
         end
         SEND:   state_d = WAIT_DONE;
         WAIT_DONE: begin
            if (done_i) begin
               gap_d   = LETTER_GAP;
               state_d = GAP;
            end
`ifdef MORSE_TIMEOUT_EN
            else if (wd_q >= TO_LIM) begin
               gap_d   = LETTER_GAP;
               set_err = 1'b1;
               state_d = GAP;
            end
`endif
         end
         // A count of N gives N idle cycles here; a count of 0 still spends one.
         GAP: begin
            if (gap_q <= GW'(1)) state_d = IDLE;
            else                 gap_d   = gap_q - GW'(1);
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q <= IDLE;
         gap_q   <= '0;
         char_q  <= '0;
         code_o  <= '0;
         len_o   <= '0;
         err_o   <= 1'b0;
      end else begin
         state_q <= state_d;
         gap_q   <= gap_d;
         if (pop) char_q <= mem[rd_ptr];
         if (load_code) begin
            code_o <= CODE_W'(rom[4:0]);
            len_o  <= 6'(rom[7:5]);
         end
         if (set_err) err_o <= 1'b1;
      end
   end
endmodule

// File: tb/tb_morse_char_encoder.sv
// Bench for morse_char_encoder: directed vector table, hand sequences for FIFO-full/reset, and random bursts
// checked against a transaction-level timing model built from dot/dash strings.
module tb_morse_char_encoder;
   localparam int LG = 16;
   localparam int WG = 64;
   localparam int TO = 100;

   logic       clk_i = 1'b0;
   logic       rst_i = 1'b1;
   logic [7:0] char_i = '0;
   logic       char_valid_i = 1'b0;
   logic       char_ready_o;
   logic [7:0] code_o;
   logic [5:0] len_o;
   logic       send_o;
   logic       done_i = 1'b0;
   logic       busy_o;
   logic       err_o;
   logic [3:0] fifo_level_o;

   morse_char_encoder #(
      .FIFO_DEPTH(8), .CODE_W(8), .LETTER_GAP_CYC(LG), .WORD_GAP_CYC(WG), .TIMEOUT_CYC(TO)
   ) dut (
      .clk_i(clk_i), .rst_i(rst_i), .char_i(char_i), .char_valid_i(char_valid_i),
      .char_ready_o(char_ready_o), .code_o(code_o), .len_o(len_o), .send_o(send_o),
      .done_i(done_i), .busy_o(busy_o), .err_o(err_o), .fifo_level_o(fifo_level_o)
   );

   always #5 clk_i = ~clk_i;

   int cyc = 0;
   always @(posedge clk_i) cyc <= cyc + 1;

   int n_chk = 0;
   int n_pass = 0;
   bit err_exp = 1'b0;
   logic [7:0] bq[$];

   string MORSE [36] = '{".-", "-...", "-.-.", "-..", ".", "..-.", "--.", "....", "..", ".---",
                         "-.-", ".-..", "--", "-.", "---", ".--.", "--.-", ".-.", "...", "-",
                         "..-", "...-", ".--", "-..-", "-.--", "--..",
                         "-----", ".----", "..---", "...--", "....-", ".....", "-....", "--...",
                         "---..", "----."};

   typedef struct { logic [7:0] ch; logic [7:0] code; logic [5:0] len; } vec_t;
   vec_t vt [8];

   task automatic check(input string name, input longint act, input longint exp);
      n_chk++;
      if (act == exp) n_pass++;
      else $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
   endtask

   // kind: 0 letter/digit, 1 space, 2 unsupported
   function automatic void ref_lookup(input logic [7:0] c, output int kind,
                                      output logic [7:0] code, output logic [5:0] len);
      string p;
      int idx = -1;
      kind = 2;
      code = '0;
      len  = '0;
      if (c >= "A" && c <= "Z")      idx = int'(c) - int'("A");
      else if (c >= "a" && c <= "z") idx = int'(c) - int'("a");
      else if (c >= "0" && c <= "9") idx = 26 + int'(c) - int'("0");
      else if (c == " ")             kind = 1;
      if (idx >= 0) begin
         kind = 0;
         p    = MORSE[idx];
         len  = 6'(p.len() - 1);
         for (int j = 0; j < p.len(); j++) if (p[j] == "-") code[j] = 1'b1;
      end
   endfunction

   task automatic do_reset();
      rst_i = 1'b1; char_valid_i = 1'b0; done_i = 1'b0;
      repeat (2) @(negedge clk_i);
      rst_i = 1'b0;
      err_exp = 1'b0;
      @(negedge clk_i);
   endtask

   task automatic push_char(input logic [7:0] c, output int n);
      char_i = c; char_valid_i = 1'b1;
      @(negedge clk_i);
      char_valid_i = 1'b0;
      n = cyc;
   endtask

   task automatic wait_send(output int t, output bit ok);
      ok = 1'b0; t = -1;
      for (int i = 0; i < 500; i++) begin
         if (send_o) begin t = cyc; ok = 1'b1; break; end
         @(negedge clk_i);
      end
   endtask

   task automatic wait_idle(output int t);
      t = -1;
      for (int i = 0; i < 500; i++) begin
         if (!busy_o) begin t = cyc; break; end
         @(negedge clk_i);
      end
   endtask

   task automatic load_str(input string s);
      bq.delete();
      for (int i = 0; i < s.len(); i++) bq.push_back(s[i]);
   endtask

   // Pushes bq back-to-back, answers each send after a random delay, and checks send timing,
   // code words and the cycle the block goes idle against a timing model of the FSM rules.
   task automatic run_burst(input int dmin, input int dmax);
      int n, c0, t, start, kind, d, k, ns, ip, done_at, end_cyc;
      int exp_t[$]; int dl[$];
      logic [7:0] exp_c[$]; logic [5:0] exp_l[$];
      logic [7:0] code; logic [5:0] len;
      n = bq.size(); c0 = cyc; t = c0 + 1;
      for (int i = 0; i < n; i++) begin
         ref_lookup(bq[i], kind, code, len);
         start = (t > c0 + 1 + i) ? t : c0 + 1 + i;
         if (kind == 0) begin
            d = int'($urandom_range(dmax, dmin));
            exp_t.push_back(start + 3); exp_c.push_back(code); exp_l.push_back(len); dl.push_back(d);
            t = start + 3 + d + 1 + LG;
         end else if (kind == 1) begin
            t = start + 3 + WG;
         end else begin
            t = start + 3;
            err_exp = 1'b1;
         end
      end
      k = 0; ns = 0; ip = 0; done_at = -1; end_cyc = -1;
      for (int step = 0; step < 4000; step++) begin
         if (send_o) begin
            ns++;
            if (k < exp_t.size()) begin
               check("send_time", cyc, exp_t[k]);
               check("send_code", code_o, exp_c[k]);
               check("send_len", len_o, exp_l[k]);
               done_at = cyc + dl[k];
               k++;
            end
         end
         if (ip == n && k == exp_t.size() && !busy_o) begin end_cyc = cyc; break; end
         char_valid_i = (ip < n);
         if (ip < n) begin char_i = bq[ip]; ip++; end
         done_i = (cyc == done_at);
         @(negedge clk_i);
      end
      char_valid_i = 1'b0; done_i = 1'b0;
      check("send_count", ns, exp_t.size());
      check("burst_idle_cycle", end_cyc, t);
      check("err_flag", err_o, err_exp);
   endtask

   initial begin : watchdog
      #900000;
      $display("FAIL global_timeout: simulation did not finish");
      $fatal(1, "timeout");
   end

   initial begin : main
      int n, s, t, dc, acc, nsend;
      bit ok;
      logic [7:0] c;

      vt[0] = '{"E", 8'h00, 6'd0};
      vt[1] = '{"A", 8'h02, 6'd1};
      vt[2] = '{"O", 8'h07, 6'd2};
      vt[3] = '{"0", 8'h1F, 6'd4};
      vt[4] = '{"a", 8'h02, 6'd1};
      vt[5] = '{"T", 8'h01, 6'd0};
      vt[6] = '{"Q", 8'h0B, 6'd3};
      vt[7] = '{"9", 8'h0F, 6'd4};

      do_reset();
      check("rst_code", code_o, 0);
      check("rst_len", len_o, 0);
      check("rst_send", send_o, 0);
      check("rst_err", err_o, 0);
      check("rst_busy", busy_o, 0);
      check("rst_level", fifo_level_o, 0);
      check("rst_ready", char_ready_o, 1);

      // Single characters: latency N+3, code word, stability while waiting, idle LG cycles after done
      for (int i = 0; i < 8; i++) begin
         push_char(vt[i].ch, n);
         wait_send(s, ok);
         check("vec_send_seen", ok, 1);
         if (ok) begin
            check("vec_latency", s - n, 3);
            check("vec_code", code_o, vt[i].code);
            check("vec_len", len_o, vt[i].len);
            dc = s + 5;
            while (cyc < dc) @(negedge clk_i);
            check("vec_code_stable", code_o, vt[i].code);
            done_i = 1'b1;
            @(negedge clk_i);
            done_i = 1'b0;
            wait_idle(t);
            check("vec_idle_after_done", t, dc + 1 + LG);
         end
      end

      load_str("aO0"); run_burst(1, 4);
      load_str("E E"); run_burst(2, 2);
      load_str("#E");  run_burst(1, 3);
      load_str("I5");  run_burst(1, 2);

      // FIFO full with the engine stuck in WAIT_DONE, then reset abandons everything
      do_reset();
      acc = 0; nsend = 0;
      for (int i = 0; i < 12; i++) begin
         c = 8'h41 + 8'(i);
         char_i = c; char_valid_i = 1'b1;
         if (char_ready_o) acc++;
         if (send_o) nsend++;
         @(negedge clk_i);
      end
      check("full_level", fifo_level_o, 8);
      check("full_ready", char_ready_o, 0);
      check("full_accepted", acc, 9);
      check("full_sends", nsend, 1);
      check("full_busy", busy_o, 1);
      char_valid_i = 1'b0;
      rst_i = 1'b1;
      @(negedge clk_i);
      rst_i = 1'b0;
      @(negedge clk_i);
      check("midrst_level", fifo_level_o, 0);
      check("midrst_ready", char_ready_o, 1);
      check("midrst_send", send_o, 0);
      check("midrst_busy", busy_o, 0);
      done_i = 1'b1;
      @(negedge clk_i);
      done_i = 1'b0;
      nsend = 0;
      repeat (5) begin
         if (send_o || busy_o) nsend++;
         @(negedge clk_i);
      end
      check("late_done_ignored", nsend, 0);

      // Random bursts of letters, digits, spaces and occasional unsupported characters
      do_reset();
      for (int b = 0; b < 6; b++) begin
         bq.delete();
         for (int i = 0; i < int'($urandom_range(8, 1)); i++) begin
            case ($urandom_range(9, 0))
               0, 1, 2: c = 8'h41 + 8'($urandom_range(25, 0));
               3, 4:    c = 8'h61 + 8'($urandom_range(25, 0));
               5, 6:    c = 8'h30 + 8'($urandom_range(9, 0));
               7:       c = 8'h20;
               8:       c = ($urandom_range(1, 0) != 0) ? 8'h23 : 8'h7F;
               default: c = 8'h45;
            endcase
            bq.push_back(c);
         end
         run_burst(1, 6);
      end

`ifdef MORSE_TIMEOUT_EN
      do_reset();
      push_char("E", n);
      wait_send(s, ok);
      check("wd_send_seen", ok, 1);
      t = -1;
      for (int i = 0; i < 400; i++) begin
         if (err_o) begin t = cyc; break; end
         @(negedge clk_i);
      end
      check("wd_err_cycle", t, s + TO + 1);
      wait_idle(t);
      check("wd_idle_cycle", t, s + TO + 1 + LG);
      done_i = 1'b1;
      @(negedge clk_i);
      done_i = 1'b0;
      @(negedge clk_i);
      check("wd_err_sticky", err_o, 1);
      check("wd_late_done_idle", busy_o, 0);
`endif

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end
endmodule
